grant_sequencer: RTL and testbench

GRANT_SEQUENCER -- requirements
Module: grant_sequencer

---
 rtl/grant_sequencer_pkg.sv | 16 +
 rtl/grant_sequencer_if.sv | 13 +
 rtl/grant_sequencer_decoder.sv | 11 +
 rtl/grant_sequencer.sv | 78 +++++++
 tb/tb_grant_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/grant_sequencer_pkg.sv
// grant_sequencer_pkg: shared types, sizes and round-robin pick for the grant sequencer
// Package arb_pkg: state encoding, requester count, address width, rr_pick helper.
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
  // Walk from the farthest candidate back to ptr so the nearest asserted bit wins.
  function automatic logic [ADDR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [ADDR_W-1:0] ptr);
    logic [ADDR_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + ADDR_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/grant_sequencer_if.sv
// grant_sequencer_if: request/grant bundle between requesters (master) and the arbiter (slave)
// Signals: req[3:0], done (from requesters); gnt[3:0], gnt_addr[1:0], gnt_valid, timeout (from arbiter).
interface grant_sequencer_if;
  import arb_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic done;
  logic [NUM_REQ-1:0] gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic gnt_valid;
  logic timeout;
  modport master (output req, done, input gnt, gnt_addr, gnt_valid, timeout);
  modport slave (input req, done, output gnt, gnt_addr, gnt_valid, timeout);
endinterface

// File: rtl/grant_sequencer_decoder.sv
// grant_decoder: 2-to-4 one-hot decoder with enable
// Ports: i_addr (binary index), i_en (enable), o_onehot (decoded, all-zero when disabled).
module grant_decoder
  import arb_pkg::*;
(
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_onehot
);
  assign o_onehot = i_en ? NUM_REQ'(1) << i_addr : '0;
endmodule

// File: rtl/grant_sequencer.sv
// grant_sequencer: round-robin 4-way grant FSM (IDLE/GRANT/RELEASE) with optional forced release
// Ports: clk, rst_n (async active-low), bus (grant_sequencer_if.slave).
// Macro ARB_TIMEOUT_EN enables the TIMEOUT_CYCLES hold limit and the timeout pulse.
module grant_sequencer
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  grant_sequencer_if.slave bus
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end
  state_t r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic r_valid;
  logic w_expire;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic r_timeout;
  assign w_expire = r_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign bus.timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_addr <= '0;
      r_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (|bus.req) begin
          r_addr <= rr_pick(bus.req, r_ptr);
          r_valid <= 1'b1;
          r_state <= GRANT;
`ifdef ARB_TIMEOUT_EN
          r_cnt <= '0;
`endif
        end
        GRANT: if (bus.done || !bus.req[r_addr] || w_expire) begin
          r_state <= RELEASE;
          r_valid <= 1'b0;
          r_ptr <= r_addr + 1'b1;
`ifdef ARB_TIMEOUT_EN
          // Only a release caused purely by the hold limit counts as forced.
          r_timeout <= w_expire && bus.req[r_addr] && !bus.done;
        end else begin
          r_cnt <= r_cnt + 8'd1;
`endif
        end
        RELEASE: begin
          r_state <= IDLE;
`ifdef ARB_TIMEOUT_EN
          r_timeout <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.gnt_addr = r_addr;
  assign bus.gnt_valid = r_valid;
  grant_decoder u_dec (
    .i_addr  (r_addr),
    .i_en    (r_valid),
    .o_onehot(bus.gnt)
  );
endmodule

// File: tb/tb_grant_sequencer.sv
// tb_grant_sequencer: scoreboard bench for grant_sequencer (directed cases plus random transactions)
module tb_grant_sequencer;
  import arb_pkg::*;
  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int MAXH = 1;
`else
  localparam int MAXH = 4;
`endif
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  grant_sequencer_if bus ();
  grant_sequencer #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int m_ptr = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // Rotate the request vector so ptr lands at bit 0, take the lowest set bit, rotate back.
  function automatic int pick(input logic [3:0] r, input int p);
    logic [7:0] d;
    logic [3:0] rot;
    d = {r, r};
    rot = 4'(d >> p);
    for (int j = 0; j < 4; j++) if (rot[j]) return (p + j) % 4;
    return -1;
  endfunction
  task automatic issue(input logic [3:0] r, output int w);
    w = pick(r, m_ptr);
    exp_q.push_back(w);
    bus.req = r;
  endtask
  task automatic wait_grant();
    int n = 0;
    while (!bus.gnt_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.gnt_valid) chk("grant_wait", 0, 1);
  endtask
  task automatic release_done(input int w);
    bus.done = 1;
    bus.req = 0;
    m_ptr = (w + 1) % 4;
    @(negedge clk);
    bus.done = 0;
  endtask
  logic prev_v = 0;
  logic [1:0] prev_a = 0;
  int gap = 0;
  bit have_prev = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
      have_prev = 0;
      gap = 0;
    end else begin
      chk("gnt_decode", 32'(bus.gnt), bus.gnt_valid ? (32'd1 << bus.gnt_addr) : 32'd0);
`ifndef ARB_TIMEOUT_EN
      chk("timeout_tied0", 32'(bus.timeout), 0);
`endif
      if (bus.gnt_valid && !prev_v) begin
        if (have_prev) chk("grant_gap_ge2", 32'(gap >= 2), 1);
        if (exp_q.size() == 0) chk("sb_unexpected_grant", 32'(bus.gnt_addr), 32'hff);
        else chk("sb_owner", 32'(bus.gnt_addr), 32'(exp_q.pop_front()));
        have_prev = 1;
      end
      if (bus.gnt_valid && prev_v) chk("owner_stable", 32'(bus.gnt_addr), 32'(prev_a));
      gap = bus.gnt_valid ? 0 : gap + 1;
      prev_v = bus.gnt_valid;
      prev_a = bus.gnt_addr;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, h, z, n;
    bus.req = 0;
    bus.done = 0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_addr", 32'(bus.gnt_addr), 0);
    chk("rst_valid", 32'(bus.gnt_valid), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(4'b0100, w);
    @(posedge clk);
    #1;
    chk("lat1_valid", 32'(bus.gnt_valid), 1);
    chk("lat1_gnt", 32'(bus.gnt), 32'b0100);
    chk("lat1_addr", 32'(bus.gnt_addr), 2);
    @(negedge clk);
    release_done(w);
    issue(4'b1000, w);
    wait_grant();
    bus.done = 1;
    m_ptr = (w + 1) % 4;
    issue(4'b0001, w);
    @(negedge clk);
    chk("done_req_release", 32'(bus.gnt_valid), 0);
    bus.done = 0;
    @(negedge clk);
    chk("done_req_idle", 32'(bus.gnt_valid), 0);
    @(negedge clk);
    chk("wrap_gnt", 32'(bus.gnt), 32'b0001);
    release_done(w);
    issue(4'b0010, w);
    wait_grant();
    bus.req = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      chk("hold_owner1", 32'(bus.gnt), 32'b0010);
    end
    m_ptr = 2;
    issue(4'b1101, w);
    chk("drop_same_cycle", 32'(bus.gnt), 32'b0010);
    @(negedge clk);
    chk("drop_release", 32'(bus.gnt_valid), 0);
    wait_grant();
    chk("grant_after_drop", 32'(bus.gnt), 32'b0100);
    release_done(w);
    issue(4'b0100, w);
    wait_grant();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_gnt", 32'(bus.gnt), 0);
    chk("async_rst_valid", 32'(bus.gnt_valid), 0);
    bus.req = 0;
    m_ptr = 0;
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    issue(4'b1010, w);
    wait_grant();
    chk("post_rst_owner", 32'(bus.gnt_addr), 1);
    release_done(w);
    @(posedge clk);
    #2 rst_n = 0;
    bus.req = 0;
    m_ptr = 0;
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    issue(4'b1111, w);
    wait_grant();
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", 32'(bus.gnt_addr), 32'(i % 4));
      @(negedge clk);
      bus.done = 1;
      m_ptr = (w + 1) % 4;
      if (i < 4) begin
        w = pick(bus.req, m_ptr);
        exp_q.push_back(w);
      end
      @(negedge clk);
      bus.done = 0;
      if (i == 4) bus.req = 0;
      else begin
        z = 0;
        while (!bus.gnt_valid && z < 8) begin
          z++;
          @(negedge clk);
        end
        chk("rr_gap_eq2", 32'(z), 2);
      end
    end
    issue(4'b0110, w);
    wait_grant();
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (bus.gnt_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("to_hold_cycles", 32'(n), 32'(TO));
    chk("to_pulse", 32'(bus.timeout), 1);
    m_ptr = (w + 1) % 4;
    w = pick(bus.req, m_ptr);
    exp_q.push_back(w);
    @(negedge clk);
    chk("to_pulse_1cyc", 32'(bus.timeout), 0);
    wait_grant();
    chk("to_next_owner", 32'(bus.gnt_addr), 2);
    release_done(w);
`else
    repeat (20) begin
      @(negedge clk);
      chk("hold_forever", 32'(bus.gnt_valid), 1);
    end
    release_done(w);
`endif
    repeat (60) begin
      issue(4'($urandom_range(1, 15)), w);
      wait_grant();
      h = $urandom_range(0, MAXH);
      repeat (h) begin
        @(negedge clk);
        bus.req = 4'($urandom) | (4'b1 << w);
        bus.done = 0;
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.done = 1;
        bus.req = 4'($urandom);
      end else bus.req = 4'($urandom) & ~(4'b1 << w);
      m_ptr = (w + 1) % 4;
      @(negedge clk);
      bus.done = 0;
    end
    bus.req = 0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
